leaky_relu_lut_pp: RTL and testbench

//  Parametrised LeakyReLU activation stage: CH_NUM parallel per-channel 2^DATA_W-entry lookup tables.

---
 rtl/leaky_relu_lut_pp_if.sv | 30 +++
 rtl/leaky_relu_lut_pp.sv | 124 ++++++++++++
 tb/tb_leaky_relu_lut_pp.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaky_relu_lut_pp_if.sv
// Pixel/LUT-load bundle of the LeakyReLU LUT stage. The master drives the load
// stream and the samples; the slave (the LUT stage) returns results and status.
interface leaky_relu_lut_pp_if #(
   parameter int CH_NUM   = 8,
   parameter int DATA_W   = 8,
   parameter int STREAM_W = 64
);
   logic [STREAM_W-1:0]        lut_wr_data;
   logic                       lut_wr_vld;
   logic                       lut_wr_last;
   logic                       bypass_en;
   logic [CH_NUM*DATA_W-1:0]   ch_data_i;
   logic                       ch_data_vld_i;
   logic [CH_NUM*DATA_W-1:0]   ch_data_o;
   logic                       ch_data_vld_o;
   logic                       lut_load_done;
   logic                       lut_load_err;
   logic                       active_bank;
   logic                       lut_valid;

   modport master (
      output lut_wr_data, lut_wr_vld, lut_wr_last, bypass_en, ch_data_i, ch_data_vld_i,
      input  ch_data_o, ch_data_vld_o, lut_load_done, lut_load_err, active_bank, lut_valid
   );

   modport slave (
      input  lut_wr_data, lut_wr_vld, lut_wr_last, bypass_en, ch_data_i, ch_data_vld_i,
      output ch_data_o, ch_data_vld_o, lut_load_done, lut_load_err, active_bank, lut_valid
   );
endinterface

// File: rtl/leaky_relu_lut_pp.sv
// LeakyReLU activation via per-channel double-banked lookup tables.
// Tables load into the shadow bank; a clean load swaps banks with no pixel stall.
module leaky_relu_lut_pp #(
   parameter int CH_NUM   = 8,
   parameter int DATA_W   = 8,
   parameter int STREAM_W = 64
) (
   input  logic                 sclk,
   input  logic                 s_rst_n,
   leaky_relu_lut_pp_if.slave   bus
);
   localparam int DEPTH = 2 ** DATA_W;
   localparam int LANES = STREAM_W / DATA_W;
   localparam int WORDS = DEPTH / LANES;
   localparam int LW    = $clog2(LANES);
   localparam int WW    = DATA_W - LW;
   localparam logic [WW-1:0] LAST_W = WW'(WORDS - 1);

   // RAM is word-wide: a load word lands in one row, lookups pick the lane on the way out.
   // This assumes at least two lanes per word (LW >= 1).
   logic [STREAM_W-1:0] mem [CH_NUM][2][WORDS];

   logic [WW-1:0]              wr_cnt;
   logic                       bank_q;
   logic                       lut_valid_q;
   logic                       done_q;
   logic                       err_q;

   logic [CH_NUM*DATA_W-1:0]   in_q;
   logic                       vld_q;
   logic                       sel_q;
   logic                       byp_q;
   logic [CH_NUM*DATA_W-1:0]   in_d;
   logic                       vld_d;
   logic                       byp_d;
   logic [STREAM_W-1:0]        rd_word [CH_NUM];
   logic [DATA_W-1:0]          lut_dat [CH_NUM];
   logic [CH_NUM*DATA_W-1:0]   out_q;
   logic                       vld_o_q;

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         wr_cnt      <= '0;
         bank_q      <= 1'b0;
         lut_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.lut_wr_vld) begin
            if (wr_cnt == LAST_W) begin
               wr_cnt <= '0;
               if (bus.lut_wr_last) begin
                  bank_q      <= ~bank_q;
                  lut_valid_q <= 1'b1;
                  done_q      <= 1'b1;
               end else begin
                  err_q <= 1'b1;
               end
            end else if (bus.lut_wr_last) begin
               wr_cnt <= '0;
               err_q  <= 1'b1;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
      end
   end

   // Contents survive reset; writes only ever hit the shadow bank.
   always_ff @(posedge sclk) begin
      if (bus.lut_wr_vld) begin
         for (int c = 0; c < CH_NUM; c++) begin
            mem[c][~bank_q][wr_cnt] <= bus.lut_wr_data;
         end
      end
   end

   always_ff @(posedge sclk) begin
      for (int c = 0; c < CH_NUM; c++) begin
         rd_word[c] <= mem[c][sel_q][in_q[c*DATA_W+LW +: WW]];
      end
   end

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         lut_dat[c] = rd_word[c][DATA_W*int'(in_d[c*DATA_W +: LW]) +: DATA_W];
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         in_q    <= '0;
         vld_q   <= 1'b0;
         sel_q   <= 1'b0;
         byp_q   <= 1'b0;
         in_d    <= '0;
         vld_d   <= 1'b0;
         byp_d   <= 1'b0;
         out_q   <= '0;
         vld_o_q <= 1'b0;
      end else begin
         in_q    <= bus.ch_data_i;
         vld_q   <= bus.ch_data_vld_i;
         sel_q   <= bank_q;
         byp_q   <= bus.bypass_en | ~lut_valid_q;
         in_d    <= in_q;
         vld_d   <= vld_q;
         byp_d   <= byp_q;
         vld_o_q <= vld_d;
         for (int c = 0; c < CH_NUM; c++) begin
            out_q[c*DATA_W +: DATA_W] <= byp_d ? in_d[c*DATA_W +: DATA_W] : lut_dat[c];
         end
      end
   end

   assign bus.ch_data_o     = out_q;
   assign bus.ch_data_vld_o = vld_o_q;
   assign bus.lut_load_done = done_q;
   assign bus.lut_load_err  = err_q;
   assign bus.active_bank   = bank_q;
   assign bus.lut_valid     = lut_valid_q;
endmodule

// File: tb/tb_leaky_relu_lut_pp.sv
// Self-checking bench for leaky_relu_lut_pp: randomized samples and loads
// compared against a table-level reference model.
module tb_leaky_relu_lut_pp;
   localparam int CH = 8, DW = 8, SW = 64, DEPTH = 256, WORDS = 32;

   logic sclk    = 1'b0;
   logic s_rst_n = 1'b0;
   always #5 sclk = ~sclk;

   leaky_relu_lut_pp_if #(.CH_NUM(CH), .DATA_W(DW), .STREAM_W(SW)) bus();
   leaky_relu_lut_pp #(.CH_NUM(CH), .DATA_W(DW), .STREAM_W(SW)) dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .bus(bus)
   );

   int nchk = 0, nbad = 0;

   // Reference model: the table lookups currently use, the table being assembled.
   logic [7:0]  cur_tbl [DEPTH];
   logic [7:0]  new_tbl [DEPTH];
   logic [7:0]  src_tbl [DEPTH];
   bit          m_valid, m_bank;
   int          ld_cnt;
   bit          h_vld [3];
   logic [63:0] h_dat [3];
   bit          exp_vld, exp_done, exp_err;
   logic [63:0] exp_dat;

   function automatic logic [7:0] leaky(int a);
      logic signed [7:0] s;
      s = a[7:0];
      if (a < 128) return a[7:0];
      return s >>> 3;
   endfunction

   function automatic logic [63:0] word_of(int k);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = src_tbl[k*8 + j];
      return w;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_bank = 0; ld_cnt = 0;
      for (int i = 0; i < 3; i++) h_vld[i] = 0;
   endtask

   // One clock: evaluate the model for what is driven now, then advance.
   task automatic step();
      logic [63:0] e;
      logic [7:0]  a;
      bit d, er;
      d = 0; er = 0;
      for (int c = 0; c < CH; c++) begin
         a = bus.ch_data_i[c*8 +: 8];
         e[c*8 +: 8] = (bus.bypass_en || !m_valid) ? a : cur_tbl[a];
      end
      if (bus.lut_wr_vld) begin
         for (int j = 0; j < 8; j++) new_tbl[ld_cnt*8 + j] = bus.lut_wr_data[j*8 +: 8];
         if (bus.lut_wr_last && ld_cnt == WORDS-1) begin
            cur_tbl = new_tbl; m_valid = 1; m_bank = !m_bank; d = 1; ld_cnt = 0;
         end else if (bus.lut_wr_last || ld_cnt == WORDS-1) begin
            er = 1; ld_cnt = 0;
         end else begin
            ld_cnt++;
         end
      end
      h_vld[2] = h_vld[1]; h_dat[2] = h_dat[1];
      h_vld[1] = h_vld[0]; h_dat[1] = h_dat[0];
      h_vld[0] = bus.ch_data_vld_i; h_dat[0] = e;
      @(posedge sclk); #1;
      exp_vld = h_vld[2]; exp_dat = h_dat[2]; exp_done = d; exp_err = er;
   endtask

   task automatic cyc(bit wv, bit wl, logic [63:0] wd, bit dv, bit byp, logic [63:0] din);
      bus.lut_wr_vld = wv; bus.lut_wr_last = wl; bus.lut_wr_data = wd;
      bus.ch_data_vld_i = dv; bus.bypass_en = byp; bus.ch_data_i = din;
      step();
   endtask

   task automatic test_reset();
      cyc_idle_inputs();
      #12;
      nchk++;
      if (bus.ch_data_o !== 64'h0 || bus.ch_data_vld_o !== 1'b0) begin
         nbad++; $display("FAIL reset_out data=%h vld=%b exp data=0 vld=0", bus.ch_data_o, bus.ch_data_vld_o);
      end
      nchk++;
      if ({bus.lut_load_done, bus.lut_load_err, bus.active_bank, bus.lut_valid} !== 4'b0) begin
         nbad++; $display("FAIL reset_flags done/err/bank/valid=%b exp 0000",
                          {bus.lut_load_done, bus.lut_load_err, bus.active_bank, bus.lut_valid});
      end
      @(posedge sclk); #1;
      s_rst_n = 1'b1;
      model_reset();
   endtask

   task automatic cyc_idle_inputs();
      bus.lut_wr_vld = 0; bus.lut_wr_last = 0; bus.lut_wr_data = '0;
      bus.ch_data_vld_i = 0; bus.bypass_en = 0; bus.ch_data_i = '0;
   endtask

   task automatic test_no_load();
      logic [63:0] din = 64'h8786_8584_8382_8180;
      cyc(0, 0, 0, 1, 0, din);
      cyc(0, 0, 0, 0, 0, 0);
      nchk++;
      if (bus.ch_data_vld_o !== 1'b0) begin
         nbad++; $display("FAIL t1_early_vld got=%b exp=0", bus.ch_data_vld_o);
      end
      cyc(0, 0, 0, 0, 0, 0);
      nchk++;
      if (bus.ch_data_vld_o !== 1'b1 || bus.ch_data_o !== din) begin
         nbad++; $display("FAIL t1_identity vld=%b data=%h exp vld=1 data=%h", bus.ch_data_vld_o, bus.ch_data_o, din);
      end
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, $urandom_range(0, 1), 0, rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t1_rand vld=%b data=%h exp vld=%b data=%h", bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
      end
   endtask

   task automatic test_clean_load();
      for (int a = 0; a < DEPTH; a++) src_tbl[a] = leaky(a);
      for (int k = 0; k < WORDS; k++) begin
         cyc(1, k == WORDS-1, word_of(k), 0, 0, 0);
         nchk++;
         if (bus.lut_load_done !== exp_done || bus.lut_load_err !== exp_err) begin
            nbad++; $display("FAIL t2_pulse word=%0d done=%b err=%b exp done=%b err=%b", k, bus.lut_load_done, bus.lut_load_err, exp_done, exp_err);
         end
      end
      nchk++;
      if (bus.lut_load_done !== 1'b1 || bus.active_bank !== 1'b1 || bus.lut_valid !== 1'b1) begin
         nbad++; $display("FAIL t2_commit done=%b bank=%b valid=%b exp 1/1/1", bus.lut_load_done, bus.active_bank, bus.lut_valid);
      end
      cyc(0, 0, 0, 1, 0, {8{8'hF0}});
      nchk++;
      if (bus.lut_load_done !== 1'b0) begin
         nbad++; $display("FAIL t2_done_width got=%b exp=0", bus.lut_load_done);
      end
      cyc(0, 0, 0, 1, 0, {8{8'h10}});
      cyc(0, 0, 0, 0, 0, 0);
      nchk++;
      if (bus.ch_data_vld_o !== 1'b1 || bus.ch_data_o !== {8{8'hFE}}) begin
         nbad++; $display("FAIL t2_neg vld=%b data=%h exp vld=1 data=%h", bus.ch_data_vld_o, bus.ch_data_o, {8{8'hFE}});
      end
      cyc(0, 0, 0, 0, 0, 0);
      nchk++;
      if (bus.ch_data_vld_o !== 1'b1 || bus.ch_data_o !== {8{8'h10}}) begin
         nbad++; $display("FAIL t2_pos vld=%b data=%h exp vld=1 data=%h", bus.ch_data_vld_o, bus.ch_data_o, {8{8'h10}});
      end
   endtask

   task automatic test_short_load();
      for (int a = 0; a < DEPTH; a++) src_tbl[a] = 8'($urandom);
      for (int k = 0; k <= 10; k++) cyc(1, k == 10, word_of(k), 0, 0, 0);
      nchk++;
      if (bus.lut_load_err !== 1'b1 || bus.lut_load_done !== 1'b0 || bus.active_bank !== 1'b1) begin
         nbad++; $display("FAIL t3_short err=%b done=%b bank=%b exp 1/0/1", bus.lut_load_err, bus.lut_load_done, bus.active_bank);
      end
      for (int i = 0; i < 24; i++) begin
         cyc(0, 0, 0, 1, 0, rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t3_old_tbl vld=%b data=%h exp vld=%b data=%h", bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
      end
   endtask

   task automatic test_long_load();
      for (int a = 0; a < DEPTH; a++) src_tbl[a] = 8'($urandom);
      for (int k = 0; k < WORDS + 2; k++) begin
         cyc(1, k == WORDS + 1, word_of(k % WORDS), 0, 0, 0);
         nchk++;
         if (bus.lut_load_err !== exp_err || bus.lut_load_done !== exp_done || bus.active_bank !== m_bank) begin
            nbad++; $display("FAIL t_long word=%0d err=%b done=%b bank=%b exp %b/%b/%b", k, bus.lut_load_err, bus.lut_load_done, bus.active_bank, exp_err, exp_done, m_bank);
         end
      end
   endtask

   task automatic test_swap_stream();
      for (int a = 0; a < DEPTH; a++) src_tbl[a] = 8'($urandom);
      for (int k = 0; k < WORDS + 4; k++) begin
         cyc(k < WORDS, k == WORDS-1, (k < WORDS) ? word_of(k) : 64'h0, 1, 0, rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t4_stream cyc=%0d vld=%b data=%h exp vld=%b data=%h", k, bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
         if (k >= 2) begin
            nchk++;
            if (bus.ch_data_vld_o !== 1'b1) begin
               nbad++; $display("FAIL t4_bubble cyc=%0d vld=%b exp=1", k, bus.ch_data_vld_o);
            end
         end
      end
      nchk++;
      if (bus.active_bank !== m_bank || m_bank !== 1'b0) begin
         nbad++; $display("FAIL t4_bank got=%b exp=0", bus.active_bank);
      end
   endtask

   task automatic test_bypass();
      for (int i = 0; i < 26; i++) begin
         cyc(0, 0, 0, i < 24, i[0], rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t5_bypass i=%0d vld=%b data=%h exp vld=%b data=%h", i, bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int a = 0; a < DEPTH; a++) src_tbl[a] = 8'($urandom);
      for (int k = 0; k <= 15; k++) cyc(1, 0, word_of(k), 1, 0, rnd64());
      #3 s_rst_n = 1'b0;
      #1;
      nchk++;
      if ({bus.ch_data_o, bus.ch_data_vld_o, bus.lut_load_done, bus.lut_load_err, bus.active_bank, bus.lut_valid} !== '0) begin
         nbad++; $display("FAIL t6_async data=%h vld=%b done=%b err=%b bank=%b valid=%b exp all 0", bus.ch_data_o,
                          bus.ch_data_vld_o, bus.lut_load_done, bus.lut_load_err, bus.active_bank, bus.lut_valid);
      end
      cyc_idle_inputs();
      model_reset();
      @(posedge sclk); #1;
      s_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, 0, rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t6_identity vld=%b data=%h exp vld=%b data=%h", bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
      end
      for (int k = 0; k < WORDS; k++) cyc(1, k == WORDS-1, word_of(k), 0, 0, 0);
      nchk++;
      if (bus.lut_load_done !== 1'b1 || bus.lut_load_err !== 1'b0 || bus.active_bank !== 1'b1 || bus.lut_valid !== 1'b1) begin
         nbad++; $display("FAIL t6_reload done=%b err=%b bank=%b valid=%b exp 1/0/1/1", bus.lut_load_done, bus.lut_load_err, bus.active_bank, bus.lut_valid);
      end
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, i < 10, 0, rnd64());
         nchk++;
         if (bus.ch_data_vld_o !== exp_vld || (exp_vld && bus.ch_data_o !== exp_dat)) begin
            nbad++; $display("FAIL t6_mapped vld=%b data=%h exp vld=%b data=%h", bus.ch_data_vld_o, bus.ch_data_o, exp_vld, exp_dat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_no_load();
      test_clean_load();
      test_short_load();
      test_long_load();
      test_swap_stream();
      test_bypass();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end
endmodule
